// File: rtl/y86_pkg.sv
// Shared Y86 constants, BHT init-FSM states and the saturating step helper.
package y86_pkg;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] C_YES = 4'h0;

    typedef enum logic {
        TBL_INIT = 1'b0,
        TBL_RUN  = 1'b1
    } tbl_state_e;

    // One saturating step up or down; callers keep their widths at or below 32 bits.
    function automatic logic [31:0] sat_step(input logic [31:0] val,
                                             input logic [31:0] max_val,
                                             input logic        up);
        if (up)
            return (val >= max_val) ? max_val : val + 32'd1;
        return (val == 32'd0) ? 32'd0 : val - 32'd1;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Counter array for the branch history table: init sweep FSM, two async read
// ports (fetch and train) and one sync write port that shares the train index.
module bht_table
    import y86_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CTR_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [CTR_BITS-1:0] rd_ctr_o,
    input  logic [IDX_BITS-1:0] tr_idx_i,
    output logic [CTR_BITS-1:0] tr_ctr_o,
    input  logic                wr_en_i,
    input  logic [CTR_BITS-1:0] wr_ctr_i,
    output logic                ready_o
);

    localparam int DEPTH = 2 ** IDX_BITS;
    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] ctr_mem [DEPTH];
    tbl_state_e          state, state_nxt;
    logic [IDX_BITS-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= TBL_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Sweep writes one entry per cycle and leaves INIT after the last index.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ready_o   = (state == TBL_RUN);
        if (state == TBL_INIT) begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == '1)
                state_nxt = TBL_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == TBL_INIT)
                ctr_mem[ptr] <= WEAK_NT;
            else if (wr_en_i)
                ctr_mem[tr_idx_i] <= wr_ctr_i;
        end
    end

    assign rd_ctr_o = ctr_mem[rd_idx_i];
    assign tr_ctr_o = ctr_mem[tr_idx_i];

endmodule

// File: rtl/bht_predictor.sv
// Fetch-stage next-PC predictor with a saturating-counter BHT and branch statistics.
// Define BHT_GSHARE_EN to hash a non-speculative global history into the index.
module bht_predictor
    import y86_pkg::*;
#(
    parameter int IDX_BITS  = 6,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 6,
    parameter int STAT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [63:0]       f_PC_i,
    input  logic [3:0]        f_icode_i,
    input  logic [3:0]        f_ifun_i,
    input  logic [63:0]       f_valC_i,
    input  logic [63:0]       f_valP_i,
    input  logic [63:0]       E_PC_i,
    input  logic [3:0]        E_icode_i,
    input  logic [3:0]        E_ifun_i,
    input  logic              E_branch_taken_i,
    input  logic              e_Cnd_i,
    output logic [63:0]       f_predPC_o,
    output logic              f_branch_taken_o,
    output logic              ready_o,
    output logic [STAT_W-1:0] branch_count_o,
    output logic [STAT_W-1:0] mis_count_o
);

    localparam logic [31:0] CTR_MAX  = 32'({CTR_BITS{1'b1}});
    localparam logic [31:0] STAT_MAX = 32'({STAT_W{1'b1}});

    logic [IDX_BITS-1:0] f_idx, e_idx;
    logic [CTR_BITS-1:0] f_ctr, e_ctr, e_ctr_nxt;
    logic                e_cond, train, f_taken;

    assign e_cond = (E_icode_i == IJXX) && (E_ifun_i != C_YES);
    assign train  = e_cond && ready_o;

`ifdef BHT_GSHARE_EN
    logic [HIST_BITS-1:0] ghr;

    // Predict and train share this cycle's history; it only advances on trained branches.
    assign f_idx = f_PC_i[IDX_BITS-1:0] ^ IDX_BITS'(ghr);
    assign e_idx = E_PC_i[IDX_BITS-1:0] ^ IDX_BITS'(ghr);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            ghr <= '0;
        else if (train)
            ghr <= HIST_BITS'({ghr, e_Cnd_i});
    end
`else
    assign f_idx = f_PC_i[IDX_BITS-1:0];
    assign e_idx = E_PC_i[IDX_BITS-1:0];
`endif

    bht_table #(
        .IDX_BITS(IDX_BITS),
        .CTR_BITS(CTR_BITS)
    ) u_table (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rd_idx_i(f_idx),
        .rd_ctr_o(f_ctr),
        .tr_idx_i(e_idx),
        .tr_ctr_o(e_ctr),
        .wr_en_i (train),
        .wr_ctr_i(e_ctr_nxt),
        .ready_o (ready_o)
    );

    assign e_ctr_nxt = CTR_BITS'(sat_step(32'(e_ctr), CTR_MAX, e_Cnd_i));

    // Conditional jumps follow the counter MSB only once the table is initialised.
    always_comb begin
        f_taken = 1'b0;
        if (f_icode_i == IJXX)
            f_taken = (f_ifun_i == C_YES) ? 1'b1 : (ready_o & f_ctr[CTR_BITS-1]);
        else if (f_icode_i == ICALL)
            f_taken = 1'b1;
    end

    assign f_branch_taken_o = f_taken;
    assign f_predPC_o       = f_taken ? f_valC_i : f_valP_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_count_o <= '0;
            mis_count_o    <= '0;
        end else if (e_cond) begin
            branch_count_o <= STAT_W'(sat_step(32'(branch_count_o), STAT_MAX, 1'b1));
            if (e_Cnd_i ^ E_branch_taken_i)
                mis_count_o <= STAT_W'(sat_step(32'(mis_count_o), STAT_MAX, 1'b1));
        end
    end

endmodule
